// File: rtl/sram_record_reader_pkg.sv
// Shared types and default geometry for the SRAM record reader.
package sram_rd_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} sram_rd_state_e;

  localparam int AW_DEF  = 10;
  localparam int DW_DEF  = 32;
  localparam int WPR_DEF = 8;
  localparam int NW_DEF  = 7;

endpackage

// File: rtl/sram_record_reader_if.sv
// Control, record-stream and SRAM-pin bundle for the record reader.
interface sram_record_reader_if
  import sram_rd_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int WPR = WPR_DEF,
  parameter int NW  = NW_DEF
);

  logic                start;
  logic [AW-1:0]       base_addr;
  logic [NW-1:0]       num_records;
  logic                busy;
  logic                done;
  logic                rec_valid;
  logic                rec_ready;
  logic [WPR*DW-1:0]   rec_data;
  logic [NW-1:0]       rec_index;
  logic                sram_cen;
  logic                sram_wen;
  logic [AW-1:0]       sram_a;
  logic [DW-1:0]       sram_q;

  // master: the reader itself
  modport master (
    input  start, base_addr, num_records, rec_ready, sram_q,
    output busy, done, rec_valid, rec_data, rec_index, sram_cen, sram_wen, sram_a
  );

  // slave: requester, record consumer and SRAM macro
  modport slave (
    output start, base_addr, num_records, rec_ready, sram_q,
    input  busy, done, rec_valid, rec_data, rec_index, sram_cen, sram_wen, sram_a
  );

endinterface

// File: rtl/sram_record_reader.sv
// Fetches WPR-word records from the single-port SRAM and presents each one
// as a wide word on a valid/ready stream.
module sram_record_reader
  import sram_rd_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int WPR = WPR_DEF,
  parameter int NW  = NW_DEF
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  sram_record_reader_if.master  bus
);

  localparam int IW = (WPR > 1) ? $clog2(WPR) : 1;

  sram_rd_state_e        state_q;
  logic [NW-1:0]         num_q;
  logic [NW-1:0]         cnt_q;
  logic                  cen_q;
  logic [AW-1:0]         a_q;
  logic [IW-1:0]         iss_idx_q;
  logic                  cap_vld_q;
  logic [IW-1:0]         cap_idx_q;
  logic [WPR*DW-1:0]     data_q;
  logic                  rec_valid_q;
  logic                  done_q;
  logic                  busy_q;

  logic [AW-1:0]         a_inc_d;
  logic                  last_issue_d;
  logic                  last_capture_d;
  logic                  last_rec_d;

  // Address wraps modulo 2^AW by plain truncation.
  assign a_inc_d        = a_q + AW'(1);
  assign last_issue_d   = (iss_idx_q == IW'(WPR - 1));
  assign last_capture_d = cap_vld_q && (cap_idx_q == IW'(WPR - 1));
  assign last_rec_d     = (cnt_q == (num_q - NW'(1)));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      num_q       <= '0;
      cnt_q       <= '0;
      cen_q       <= 1'b1;
      a_q         <= '0;
      iss_idx_q   <= '0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
      data_q      <= '0;
      rec_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      // SRAM returns data one cycle after the issue; the delayed flag/index
      // steer that data into its slot.
      cap_vld_q <= !cen_q;
      cap_idx_q <= iss_idx_q;
      if (cap_vld_q) begin
        data_q[int'(cap_idx_q)*DW +: DW] <= bus.sram_q;
      end

      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            num_q <= bus.num_records;
            cnt_q <= '0;
            if (bus.num_records == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= FETCH;
              busy_q    <= 1'b1;
              cen_q     <= 1'b0;
              a_q       <= bus.base_addr;
              iss_idx_q <= '0;
            end
          end
        end

        FETCH: begin
          if (!cen_q) begin
            if (last_issue_d) begin
              cen_q <= 1'b1;
            end else begin
              iss_idx_q <= iss_idx_q + IW'(1);
              a_q       <= a_inc_d;
            end
          end
          if (last_capture_d) begin
            state_q     <= HOLD;
            rec_valid_q <= 1'b1;
          end
        end

        HOLD: begin
          if (rec_valid_q && bus.rec_ready) begin
            rec_valid_q <= 1'b0;
            if (last_rec_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              // Next record continues at the word after the previous one.
              state_q   <= FETCH;
              cnt_q     <= cnt_q + NW'(1);
              cen_q     <= 1'b0;
              a_q       <= a_inc_d;
              iss_idx_q <= '0;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rec_valid = rec_valid_q;
  assign bus.rec_data  = data_q;
  assign bus.rec_index = cnt_q;
  assign bus.sram_cen  = cen_q;
  assign bus.sram_wen  = 1'b1;
  assign bus.sram_a    = a_q;

endmodule

// File: tb/tb_sram_record_reader.sv
// Bench for sram_record_reader: SRAM model, record scoreboard, vector table.
module tb_sram_record_reader;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int WPR = 8;
  localparam int NW  = 7;

  typedef struct {
    logic [255:0] data;
    int           idx;
  } rec_t;

  typedef struct {
    int base;
    int num;
    int mode;        // 0: rec_ready held high, 1: random stalls
    int glitch;      // cycle at which a stray start is pulsed, -1 none
    int exp_cycles;  // edges from accept to done, -1 unchecked
    int exp_first;   // edges from accept to first rec_valid, -1 none
  } vec_t;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  sram_record_reader_if #(.AW(AW), .DW(DW), .WPR(WPR), .NW(NW)) bus ();

  sram_record_reader #(.AW(AW), .DW(DW), .WPR(WPR), .NW(NW)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  logic [31:0] mem [0:1023];

  always @(posedge CLK) begin
    if (!bus.sram_cen && bus.sram_wen) bus.sram_q <= mem[bus.sram_a];
  end

  int n_chk = 0;
  int n_pass = 0;
  rec_t sb[$];
  int obs_addr[$];
  int exp_addr[$];
  logic [255:0] last_data;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Stream monitor: scoreboard pops, stall stability, SRAM idle in HOLD.
  logic         prev_v = 1'b0;
  logic         prev_r = 1'b0;
  logic [255:0] prev_d = '0;
  rec_t         mon_r;

  always @(negedge CLK) begin
    if (RSTN) begin
      if (prev_v && !prev_r) begin
        chk("stall_valid", 256'(bus.rec_valid), 256'(1));
        chk("stall_data", bus.rec_data, prev_d);
      end
      if (bus.rec_valid) chk("hold_cen", 256'(bus.sram_cen), 256'(1));
      if (!bus.sram_cen) obs_addr.push_back(int'(bus.sram_a));
      if (bus.rec_valid && bus.rec_ready) begin
        if (sb.size() == 0) begin
          chk("sb_extra_record", 256'(1), 256'(0));
        end else begin
          mon_r = sb.pop_front();
          chk("rec_data", bus.rec_data, mon_r.data);
          chk("rec_index", 256'(bus.rec_index), 256'(mon_r.idx));
          last_data <= bus.rec_data;
        end
      end
      prev_v <= bus.rec_valid;
      prev_r <= bus.rec_ready;
      prev_d <= bus.rec_data;
    end else begin
      prev_v <= 1'b0;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"},      256'(bus.busy),      256'(0));
    chk({tag, "_done"},      256'(bus.done),      256'(0));
    chk({tag, "_rec_valid"}, 256'(bus.rec_valid), 256'(0));
    chk({tag, "_rec_data"},  bus.rec_data,        256'(0));
    chk({tag, "_rec_index"}, 256'(bus.rec_index), 256'(0));
    chk({tag, "_sram_cen"},  256'(bus.sram_cen),  256'(1));
    chk({tag, "_sram_wen"},  256'(bus.sram_wen),  256'(1));
    chk({tag, "_sram_a"},    256'(bus.sram_a),    256'(0));
  endtask

  task automatic run_test(input vec_t v);
    int c, first, stall, bad, a;
    bit finished, seen_busy, seen_cen_low;
    rec_t r;
    exp_addr.delete();
    obs_addr.delete();
    for (int i = 0; i < v.num; i++) begin
      r.data = '0;
      r.idx  = i;
      for (int k = 0; k < WPR; k++) begin
        a = (v.base + i * WPR + k) % 1024;
        r.data[k*32 +: 32] = mem[a];
        exp_addr.push_back(a);
      end
      sb.push_back(r);
    end
    bus.start       = 1'b1;
    bus.base_addr   = AW'(v.base);
    bus.num_records = NW'(v.num);
    bus.rec_ready   = 1'b1;
    @(posedge CLK); #1;
    bus.start       = 1'b0;
    bus.base_addr   = AW'($urandom);
    bus.num_records = NW'($urandom_range(1, 127));
    c = 0; first = -1; stall = 0;
    finished = 0; seen_busy = 0; seen_cen_low = 0;
    while (c < 3000) begin
      if (bus.busy) seen_busy = 1;
      if (!bus.sram_cen) seen_cen_low = 1;
      if (bus.rec_valid && first < 0) first = c;
      if (bus.done) begin
        finished = 1;
        break;
      end
      if (c == v.glitch) begin
        bus.start       = 1'b1;
        bus.base_addr   = AW'(500);
        bus.num_records = NW'(5);
      end else begin
        bus.start = 1'b0;
      end
      if (v.mode != 0) begin
        if (stall >= 5) bus.rec_ready = 1'b1;
        else bus.rec_ready = 1'($urandom_range(0, 1));
        stall = bus.rec_ready ? 0 : stall + 1;
      end
      @(posedge CLK); #1;
      c++;
    end
    chk("done_reached", 256'(finished), 256'(1));
    if (v.exp_cycles >= 0) chk("cycles_to_done", 256'(c), 256'(v.exp_cycles));
    if (v.exp_first >= 0) chk("first_valid_latency", 256'(first), 256'(v.exp_first));
    chk("busy_at_done", 256'(bus.busy), 256'(0));
    chk("sb_drained", 256'(sb.size()), 256'(0));
    chk("addr_count", 256'(obs_addr.size()), 256'(exp_addr.size()));
    bad = 0;
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      if (obs_addr[i] != exp_addr[i]) bad++;
    end
    chk("addr_seq", 256'(bad), 256'(0));
    if (v.num == 0) begin
      chk("num0_busy_seen", 256'(seen_busy), 256'(0));
      chk("num0_cen_low_seen", 256'(seen_cen_low), 256'(0));
    end
    bus.rec_ready = 1'b1;
    @(posedge CLK); #1;
    chk("done_one_cycle", 256'(bus.done), 256'(0));
    sb.delete();
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8,    1,  0, -1, 10,  9};
    vecs[1] = '{0,    17, 0, -1, 170, 9};
    vecs[2] = '{1020, 1,  0, -1, 10,  9};
    vecs[3] = '{40,   5,  1, 3,  -1,  9};
    vecs[4] = '{0,    0,  0, -1, 0,   -1};
    vecs[5] = '{1016, 3,  1, -1, -1,  9};

    for (int a = 0; a < 1024; a++) begin
      if (a % 8 == 0) mem[a] = 32'(a / 8);
      else mem[a] = 32'hC0DE0000 ^ 32'(a * 40503);
    end
    mem[8]  = 32'h00000001; mem[9]  = 32'h3F68F5C2;
    mem[10] = 32'h42A00000; mem[11] = 32'h42700000;
    mem[12] = 32'h42F00000; mem[13] = 32'h42C80000;
    mem[14] = 32'h00000000; mem[15] = 32'h00000001;

    bus.start = 1'b0; bus.base_addr = '0; bus.num_records = '0;
    bus.rec_ready = 1'b1;
    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_values("por");
    RSTN = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 6; i++) begin
      run_test(vecs[i]);
      if (i == 0) chk("rec0_word1", 256'(last_data[63:32]), 256'(32'h3F68F5C2));
    end

    // Asynchronous reset while word 3 of a record is being issued.
    sb.delete();
    bus.start = 1'b1; bus.base_addr = AW'(300); bus.num_records = NW'(2);
    @(posedge CLK); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("pre_reset_addr", 256'(bus.sram_a), 256'(303));
    chk("pre_reset_cen", 256'(bus.sram_cen), 256'(0));
    RSTN = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge CLK); #1;
    RSTN = 1'b1;
    sb.delete();
    @(posedge CLK); #1;
    run_test('{64, 2, 0, -1, 20, 9});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
